// File: rtl/mu0_pkg.sv
// Shared definitions for the MU0 memory responder: default bus widths,
// wait-counter width and the responder FSM state encoding.
package mu0_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 16;

    // Wait counter covers the full 0..15 wait-state range.
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mu0_mem_resp_if.sv
// MU0 core <-> memory bus: request from the core, Ready/RdData/Busy/Err back.
interface mu0_mem_resp_if
    import mu0_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);

    logic [ADDR_W-1:0] Addr;
    logic              Rd;
    logic              Wr;
    logic [DATA_W-1:0] WrData;
    logic [DATA_W-1:0] RdData;
    logic              Ready;
    logic              Busy;
    logic              Err;

    modport master (
        output Addr, Rd, Wr, WrData,
        input  RdData, Ready, Busy, Err
    );

    modport slave (
        input  Addr, Rd, Wr, WrData,
        output RdData, Ready, Busy, Err
    );

endinterface

// File: rtl/mu0_ram_sync.sv
// Single-port word RAM: one access per strobe, synchronous write and
// registered read; the read register keeps its value between reads.
module mu0_ram_sync #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              strobe,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // NOTE: the array deliberately has no reset so it maps onto block RAM;
    // contents survive Reset and only the read register is cleared.
    always_ff @(posedge clk) begin
        if (strobe && we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (strobe && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mu0_mem_resp.sv
// MU0 memory responder: accepts Rd/Wr, inserts WAIT_CYCLES wait states,
// then performs the RAM access and pulses Ready for one cycle.
module mu0_mem_resp
    import mu0_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1
) (
    input  logic           Clk,
    input  logic           Reset,
    mu0_mem_resp_if.slave  bus
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_t            state;
    state_t            next_state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic              err_q;

    logic              req_one;
    logic              req_both;
    logic              accept;
    logic              strobe;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_we;

    assign req_one  = bus.Rd ^ bus.Wr;
    assign req_both = bus.Rd & bus.Wr;

    // NOTE: state and all other registers use <= so every flop samples the
    // pre-edge values; = here would create order-dependent simulation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        strobe     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_one) begin
                    accept = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        next_state = RESP;
                        strobe     = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (wait_cnt == CNT_W'(1)) begin
                    next_state = RESP;
                    strobe     = 1'b1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        // An access not yet committed when Reset hits is dropped entirely.
        if (Reset) begin
            strobe = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wait_cnt <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state == IDLE) && req_both;
            if (accept) begin
                addr_q   <= bus.Addr;
                wdata_q  <= bus.WrData;
                wr_q     <= bus.Wr;
                wait_cnt <= WAIT_LOAD;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
        end
    end

    // With zero wait states the access happens on the accepting edge,
    // before the latches are loaded, so the live request is used then.
    assign acc_addr  = (state == IDLE) ? bus.Addr   : addr_q;
    assign acc_wdata = (state == IDLE) ? bus.WrData : wdata_q;
    assign acc_we    = (state == IDLE) ? bus.Wr     : wr_q;

    mu0_ram_sync #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (Clk),
        .rst    (Reset),
        .strobe (strobe),
        .we     (acc_we),
        .addr   (acc_addr),
        .wdata  (acc_wdata),
        .rdata  (bus.RdData)
    );

    assign bus.Ready = (state == RESP);
    assign bus.Busy  = (state != IDLE);
    assign bus.Err   = err_q;

endmodule

// File: doc/mu0_mem_resp.md
Name: mu0_mem_resp

Overview:
Memory-side responder for the MU0 processor bus. It services the Rd/Wr requests that the datapath issues from its address and accumulator registers. It holds a word-addressed single-port RAM, inserts a programmable number of wait states, and returns a one-cycle Ready pulse with registered read data. It sits between the MU0 core and its program/data store, and is the slave end of the core's memory interface.

Parameters:
ADDR_W, 12, word address width (MU0 12-bit operand field)
DATA_W, 16, data word width
WAIT_CYCLES, 1, wait states inserted between acceptance and Ready (legal range 0..15)

Ports:
Clk  input  1  system clock, all state changes on rising edge
Reset  input  1  synchronous, active-high reset
Addr  input  ADDR_W  word address from core
Rd  input  1  read request, held high until Ready seen
Wr  input  1  write request, held high until Ready seen
WrData  input  DATA_W  write data from core
RdData  output  DATA_W  registered read data
Ready  output  1  one-cycle completion pulse
Busy  output  1  high while a request is in flight (WAIT or RESP state)
Err  output  1  one-cycle pulse on illegal request (Rd and Wr both high)

Behaviour:
- Reset (synchronous, active-high, sampled on posedge Clk):
  - state goes to IDLE; RdData=0, Ready=0, Busy=0, Err=0, wait counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting wait states.
  - RESP: Ready cycle.
- IDLE transitions:
  - Exactly one of Rd/Wr high in cycle N: latch Addr, WrData and the op. Load counter with WAIT_CYCLES. Next state is WAIT, or RESP when WAIT_CYCLES=0.
  - Rd and Wr both high: no latch, no RAM access, stay in IDLE, Err=1 in cycle N+1 only.
  - Neither high: stay in IDLE.
- WAIT: counter decrements each cycle. Move to RESP on the edge where the counter reaches 1 (i.e. after WAIT_CYCLES cycles in WAIT).
- RESP: Ready=1 for exactly one cycle, then return to IDLE. Ready=1 in cycle N+1+WAIT_CYCLES.
- Read data timing: for reads, RdData is loaded with mem[latched Addr] on the edge that enters RESP. RdData holds that value until the next read completes. Writes and errors do not change RdData.
- Write timing: mem[latched Addr] is written with latched WrData on the edge that enters RESP. Read-after-write to the same address therefore returns the new data.
- Input changes: changes on Addr/WrData/Rd/Wr after acceptance are ignored until the state returns to IDLE.
- Busy=1 in WAIT and RESP, 0 in IDLE.
- Back-to-back requests: the core drops its request at the end of the Ready cycle. A request present in the cycle after Ready (IDLE) is accepted. Throughput is one access per WAIT_CYCLES+2 cycles.
- Request still high in the cycle after Ready: treated as a new request. It is the core's duty to deassert.
- Reset mid-operation: the in-flight access is aborted. A write not yet committed (RESP not entered) is never performed. No Ready is issued.
- Address wrap: none needed. The full 2^ADDR_W space is implemented and any Addr value is legal.

Decomposition:
- Package mu0_pkg: ADDR_W/DATA_W defaults and the state enum {IDLE, WAIT, RESP}.
- Sub-module mu0_ram_sync: 2^ADDR_W x DATA_W array with a synchronous write-enable port and registered read port, driven by the FSM's latched address/data and a one-cycle access strobe.
- Top level holds the FSM, wait counter and request latches.

Test Plan:
1. Reset with WAIT_CYCLES=1; Wr addr 0x005 data 0xBEEF accepted in cycle 0 -> Ready=1 in cycle 2 only; Busy=1 in cycles 1-2; RdData stays 0x0000.
2. Rd addr 0x005 after test 1 -> Ready in cycle 2 of the access, RdData=0xBEEF from that cycle; RdData holds 0xBEEF while idle.
3. WAIT_CYCLES=0 instance: Rd addr 0xFFF after writing 0x1234 there -> Ready in cycle 1, RdData=0x1234; back-to-back Rd addr 0x000 issued the cycle after Ready -> accepted, Ready two cycles later.
4. Rd and Wr both high at addr 0x010 with WrData 0xAAAA -> Err pulse one cycle later, no Ready, Busy stays 0; a subsequent Rd of 0x010 returns the old contents.
5. WAIT_CYCLES=3; Wr addr 0x020 data 0x5555; Reset asserted in the second WAIT cycle -> no Ready, state IDLE; a later Rd of 0x020 does not return 0x5555.
6. Addr/WrData changed to 0x021/0x0F0F one cycle after acceptance of Wr 0x020/0x1111 -> mem[0x020]=0x1111 and mem[0x021] is unchanged (checked by reads).
